// File: rtl/svc_axil_mem_rd.sv
// AXI-lite read subordinate fronting a 1-cycle-latency synchronous memory.
// Out-of-range word addresses answer DECERR with zero data, in request order.
module svc_axil_mem_rd #(
  parameter int AXIL_ADDR_WIDTH = 20,
  parameter int AXIL_DATA_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axil_arvalid,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic                       s_axil_arready,
  output logic                       s_axil_rvalid,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  input  logic                       s_axil_rready,
  output logic                       mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_raddr,
  input  logic [AXIL_DATA_WIDTH-1:0] mem_rdata
);
  localparam int OFFSET_W = $clog2(AXIL_DATA_WIDTH / 8);
  localparam int WORD_W   = AXIL_ADDR_WIDTH - OFFSET_W;
  localparam int DEPTH    = 3;

  logic [WORD_W-1:0]          word_addr;
  logic                       dec_err;
  logic                       ar_hs;
  logic                       p_valid;
  logic                       p_err;
  logic [1:0]                 count;
  logic [2:0]                 occupancy;
  logic [AXIL_DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [1:0]                 fifo_resp [DEPTH];
  logic                       push;
  logic                       pop;
  logic [AXIL_DATA_WIDTH-1:0] push_data;
  logic [1:0]                 push_resp;
  logic [1:0]                 wr_idx;

  assign word_addr = s_axil_araddr[AXIL_ADDR_WIDTH-1:OFFSET_W];
  assign mem_raddr = word_addr[MEM_ADDR_WIDTH-1:0];

  if (WORD_W > MEM_ADDR_WIDTH) begin : g_dec
    assign dec_err = |word_addr[WORD_W-1:MEM_ADDR_WIDTH];
  end else begin : g_nodec
    assign dec_err = 1'b0;
  end

  if (OFFSET_W > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^s_axil_araddr[OFFSET_W-1:0];
  end

  // Credit check uses only registered state so arready never depends on
  // rready or arvalid; pending stage plus FIFO can never exceed the depth.
  assign occupancy      = {2'b00, p_valid} + {1'b0, count};
  assign s_axil_arready = (occupancy < 3'd3) && !rst;
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign mem_ren        = ar_hs && !dec_err;

  assign s_axil_rvalid = (count != 2'd0);
  assign s_axil_rdata  = fifo_data[0];
  assign s_axil_rresp  = fifo_resp[0];

  assign push      = p_valid;
  assign pop       = s_axil_rvalid && s_axil_rready;
  assign push_data = p_err ? '0 : mem_rdata;
  assign push_resp = p_err ? 2'b11 : 2'b00;
  assign wr_idx    = pop ? count - 2'd1 : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_err   <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_resp[i] <= 2'b00;
      end
    end else begin
      p_valid <= ar_hs;
      p_err   <= ar_hs && dec_err;
      // Entry 0 is the head; pop shifts down, push lands behind the last live entry.
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_data[i] <= fifo_data[i+1];
          fifo_resp[i] <= fifo_resp[i+1];
        end
      end
      if (push) begin
        fifo_data[wr_idx] <= push_data;
        fifo_resp[wr_idx] <= push_resp;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_svc_axil_mem_rd.sv
// Directed bench for svc_axil_mem_rd with a 1-cycle synchronous memory model
// whose word a holds {4'hD, a[11:0]}.
module tb_svc_axil_mem_rd;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axil_arvalid = 1'b0;
  logic [19:0] s_axil_araddr = '0;
  logic        s_axil_arready;
  logic        s_axil_rvalid;
  logic [15:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rready = 1'b0;
  logic        mem_ren;
  logic [11:0] mem_raddr;
  logic [15:0] mem_rdata = '0;

  int checks = 0;
  int passed = 0;

  svc_axil_mem_rd dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arready (s_axil_arready),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rready  (s_axil_rready),
    .mem_ren        (mem_ren),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= {4'hD, mem_raddr};
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({s_axil_arready, s_axil_rvalid, s_axil_rresp, s_axil_rdata, mem_ren} !== 21'h0) begin
      $display("FAIL reset_outputs: got arready=%b rvalid=%b rresp=%b rdata=%h mem_ren=%b, want all zero",
               s_axil_arready, s_axil_rvalid, s_axil_rresp, s_axil_rdata, mem_ren);
    end else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({s_axil_arready, s_axil_rvalid} !== 2'b10) begin
      $display("FAIL reset_release: got arready=%b rvalid=%b, want arready=1 rvalid=0",
               s_axil_arready, s_axil_rvalid);
    end else passed++;
  endtask

  task automatic test_single();
    @(negedge clk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 20'h00004;
    s_axil_rready  = 1'b1;
    #1;
    checks++;
    if ({mem_ren, s_axil_arready, mem_raddr} !== {1'b1, 1'b1, 12'h002}) begin
      $display("FAIL single_req: got mem_ren=%b arready=%b mem_raddr=%h, want 1 1 002",
               mem_ren, s_axil_arready, mem_raddr);
    end else passed++;
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    #1;
    checks++;
    if (s_axil_rvalid !== 1'b0) begin
      $display("FAIL single_n1: got rvalid=%b, want 0", s_axil_rvalid);
    end else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 16'hD002}) begin
      $display("FAIL single_n2: got rvalid=%b rresp=%b rdata=%h, want 1 00 d002",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end else passed++;
    @(negedge clk);
    #1;
    checks++;
    if (s_axil_rvalid !== 1'b0) begin
      $display("FAIL single_drain: got rvalid=%b, want 0", s_axil_rvalid);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data [4] = '{16'hD500, 16'hD501, 16'hD502, 16'hD503};
    s_axil_rready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 4) begin
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = 20'h00A00 + 20'(2 * c);
      end else begin
        s_axil_arvalid = 1'b0;
      end
      #1;
      if (c < 4) begin
        checks++;
        if ({s_axil_arready, mem_ren} !== 2'b11) begin
          $display("FAIL b2b_accept[%0d]: got arready=%b mem_ren=%b, want 1 1", c, s_axil_arready, mem_ren);
        end else passed++;
      end
      if (c >= 2 && c < 6) begin
        checks++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, exp_data[c-2]}) begin
          $display("FAIL b2b_resp[%0d]: got rvalid=%b rresp=%b rdata=%h, want 1 00 %h",
                   c - 2, s_axil_rvalid, s_axil_rresp, s_axil_rdata, exp_data[c-2]);
        end else passed++;
      end
      if (c == 6) begin
        checks++;
        if (s_axil_rvalid !== 1'b0) begin
          $display("FAIL b2b_drain: got rvalid=%b, want 0", s_axil_rvalid);
        end else passed++;
      end
    end
  endtask

  task automatic test_decode_error();
    logic [19:0] addr [4]     = '{20'h00006, 20'h02000, 20'h00008, 20'h0A000};
    logic        exp_ren [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] exp_data [4] = '{16'hD003, 16'h0000, 16'hD004, 16'h0000};
    logic [1:0]  exp_resp [4] = '{2'b00, 2'b11, 2'b00, 2'b11};
    s_axil_rready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        s_axil_arvalid = 1'b1;
        s_axil_araddr  = addr[c];
      end else begin
        s_axil_arvalid = 1'b0;
      end
      #1;
      if (c < 4) begin
        checks++;
        if ({s_axil_arready, mem_ren} !== {1'b1, exp_ren[c]}) begin
          $display("FAIL decerr_ren[%0d]: got arready=%b mem_ren=%b, want 1 %b",
                   c, s_axil_arready, mem_ren, exp_ren[c]);
        end else passed++;
      end
      if (c >= 2) begin
        checks++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, exp_resp[c-2], exp_data[c-2]}) begin
          $display("FAIL decerr_resp[%0d]: got rvalid=%b rresp=%b rdata=%h, want 1 %b %h",
                   c - 2, s_axil_rvalid, s_axil_rresp, s_axil_rdata, exp_resp[c-2], exp_data[c-2]);
        end else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] exp_data [3] = '{16'hD008, 16'hD009, 16'hD00A};
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b1;
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_arready} !== 2'b01) begin
      $display("FAIL bp_idle: got rvalid=%b arready=%b, want 0 1", s_axil_rvalid, s_axil_arready);
    end else passed++;
    s_axil_rready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_axil_arvalid = 1'b1;
      s_axil_araddr  = 20'h00010 + 20'(2 * c);
      #1;
      checks++;
      if (s_axil_arready !== exp_rdy[c]) begin
        $display("FAIL bp_arready[%0d]: got %b, want %b", c, s_axil_arready, exp_rdy[c]);
      end else passed++;
      if (c >= 3) begin
        checks++;
        if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 16'hD008}) begin
          $display("FAIL bp_hold[%0d]: got rvalid=%b rdata=%h, want 1 d008", c, s_axil_rvalid, s_axil_rdata);
        end else passed++;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_axil_arvalid = 1'b0;
      s_axil_rready  = 1'b1;
      #1;
      if (c < 3) begin
        checks++;
        if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_arready} !== {1'b1, 2'b00, exp_data[c], c != 0}) begin
          $display("FAIL bp_drain[%0d]: got rvalid=%b rresp=%b rdata=%h arready=%b, want 1 00 %h %b",
                   c, s_axil_rvalid, s_axil_rresp, s_axil_rdata, s_axil_arready, exp_data[c], c != 0);
        end else passed++;
      end else begin
        checks++;
        if (s_axil_rvalid !== 1'b0) begin
          $display("FAIL bp_empty: got rvalid=%b, want 0", s_axil_rvalid);
        end else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    s_axil_rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_axil_arvalid = (c < 2);
      s_axil_araddr  = 20'h00020 + 20'(2 * c);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_rdata} !== {1'b1, 16'hD010}) begin
      $display("FAIL rst_buffered: got rvalid=%b rdata=%h, want 1 d010", s_axil_rvalid, s_axil_rdata);
    end else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_arready, mem_ren, s_axil_rresp, s_axil_rdata} !== 21'h0) begin
      $display("FAIL rst_async: got rvalid=%b arready=%b mem_ren=%b rresp=%b rdata=%h, want all zero",
               s_axil_rvalid, s_axil_arready, mem_ren, s_axil_rresp, s_axil_rdata);
    end else passed++;
    @(negedge clk);
    rst = 1'b0;
    s_axil_rready = 1'b1;
    #1;
    checks++;
    if ({s_axil_arready, s_axil_rvalid} !== 2'b10) begin
      $display("FAIL rst_release: got arready=%b rvalid=%b, want 1 0", s_axil_arready, s_axil_rvalid);
    end else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (s_axil_rvalid !== 1'b0) begin
        $display("FAIL rst_stale[%0d]: got rvalid=%b, want 0", c, s_axil_rvalid);
      end else passed++;
    end
    @(negedge clk);
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = 20'h00000;
    @(negedge clk);
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({s_axil_rvalid, s_axil_rresp, s_axil_rdata} !== {1'b1, 2'b00, 16'hD000}) begin
      $display("FAIL rst_new_read: got rvalid=%b rresp=%b rdata=%h, want 1 00 d000",
               s_axil_rvalid, s_axil_rresp, s_axil_rdata);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_decode_error();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
